banked_memory: RTL and testbench

- Parametrised successor to the flat two-region memory: word-addressed store split into a static bank and a dynamic bank, each with its own base and depth.
- Adds a valid/ready request/response handshake, synchronous (registered) reads, byte-enable writes, a static-region write lock, and error responses for unmapped or illegal accesses.
- Sits between the core's load/store/fetch unit and on-chip storage; one outstanding response, full throughput of one request per cycle.

---
 rtl/banked_memory_pkg.sv | 32 +++
 rtl/banked_memory_mem_bank.sv | 35 +++
 rtl/banked_memory.sv | 147 ++++++++++++++
 tb/tb_banked_memory.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/banked_memory_pkg.sv
// Shared types and default memory map for the banked on-chip memory.
package banked_memory_pkg;

    localparam int MemAddrWidth        = 16;
    localparam int MemDataWidth        = 32;
    localparam int MemStaticStartFrom  = 0;
    localparam int MemStaticSpace      = 1024;
    localparam int MemDynamicStartFrom = 4096;
    localparam int MemDynamicSpace     = 2048;

    typedef logic [MemAddrWidth-1:0] addr_t;
    typedef logic [MemDataWidth-1:0] op_t;

    typedef enum logic [1:0] {
        MEM_OK       = 2'd0,
        MEM_UNMAPPED = 2'd1,
        MEM_WPROT    = 2'd2
    } mem_err_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_RESP = 1'b1
    } mem_state_t;

    // Which bank, if any, drives the pending response data.
    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_STATIC  = 2'd1,
        SRC_DYNAMIC = 2'd2
    } mem_src_t;

endpackage

// File: rtl/banked_memory_mem_bank.sv
// Single-port synchronous RAM bank: byte-enable write, registered read.
module mem_bank #(
    parameter int Depth     = 1024,
    parameter int DataWidth = 32,
    parameter int IdxWidth  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [DataWidth/8-1:0] be,
    input  logic [IdxWidth-1:0]    idx,
    input  logic [DataWidth-1:0]   wdata,
    output logic [DataWidth-1:0]   rdata
);

    localparam int unsigned NumBytes = DataWidth / 8;

    logic [DataWidth-1:0] mem [Depth];

    // Read data only moves on a read access, so it holds for a stalled response.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < NumBytes; i++) begin
                    if (be[i]) begin
                        mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/banked_memory.sv
// Two-bank word memory with valid/ready request/response handshake,
// address decode, static write lock and error responses.
module banked_memory
    import banked_memory_pkg::*;
#(
    parameter int DataWidth    = MemDataWidth,
    parameter int AddrWidth    = MemAddrWidth,
    parameter int StaticBase   = MemStaticStartFrom,
    parameter int StaticDepth  = MemStaticSpace,
    parameter int DynamicBase  = MemDynamicStartFrom,
    parameter int DynamicDepth = MemDynamicSpace
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [AddrWidth-1:0]   req_addr,
    input  logic [DataWidth-1:0]   req_wdata,
    input  logic [DataWidth/8-1:0] req_be,
    input  logic                   static_lock,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DataWidth-1:0]   rsp_rdata,
    output logic [1:0]             rsp_err
);

    localparam int SIdxW = (StaticDepth > 1) ? $clog2(StaticDepth) : 1;
    localparam int DIdxW = (DynamicDepth > 1) ? $clog2(DynamicDepth) : 1;

    localparam logic [AddrWidth:0] SLo = (AddrWidth+1)'(StaticBase);
    localparam logic [AddrWidth:0] SHi = (AddrWidth+1)'(StaticBase + StaticDepth);
    localparam logic [AddrWidth:0] DLo = (AddrWidth+1)'(DynamicBase);
    localparam logic [AddrWidth:0] DHi = (AddrWidth+1)'(DynamicBase + DynamicDepth);

    generate
        if (DataWidth % 8 != 0) begin : g_bad_width
            $error("banked_memory: DataWidth must be a multiple of 8");
        end
        if (!((StaticBase + StaticDepth <= DynamicBase) ||
              (DynamicBase + DynamicDepth <= StaticBase))) begin : g_overlap
            $error("banked_memory: static and dynamic regions overlap");
        end
    endgenerate

    mem_state_t state_q, state_d;
    mem_err_t   err_q, err_d;
    mem_src_t   src_q, src_d;

    logic [AddrWidth:0] addr_ext;
    logic               s_hit, d_hit, wprot, accept;
    logic               s_en, d_en;
    logic [SIdxW-1:0]   s_idx;
    logic [DIdxW-1:0]   d_idx;
    logic [DataWidth-1:0] s_rdata, d_rdata;

    // One extra address bit keeps base+depth from wrapping at the top of the map.
    assign addr_ext = {1'b0, req_addr};
    assign s_hit    = (addr_ext >= SLo) && (addr_ext < SHi);
    assign d_hit    = (addr_ext >= DLo) && (addr_ext < DHi);
    assign s_idx    = SIdxW'(req_addr - AddrWidth'(StaticBase));
    assign d_idx    = DIdxW'(req_addr - AddrWidth'(DynamicBase));

    assign req_ready = (state_q == MEM_IDLE) || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign wprot     = req_write && s_hit && static_lock;
    assign s_en      = accept && s_hit && !wprot;
    assign d_en      = accept && d_hit;

    mem_bank #(
        .Depth     (StaticDepth),
        .DataWidth (DataWidth)
    ) u_static_bank (
        .clk   (clk),
        .en    (s_en),
        .we    (req_write),
        .be    (req_be),
        .idx   (s_idx),
        .wdata (req_wdata),
        .rdata (s_rdata)
    );

    mem_bank #(
        .Depth     (DynamicDepth),
        .DataWidth (DataWidth)
    ) u_dynamic_bank (
        .clk   (clk),
        .en    (d_en),
        .we    (req_write),
        .be    (req_be),
        .idx   (d_idx),
        .wdata (req_wdata),
        .rdata (d_rdata)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        src_d   = src_q;
        if (accept) begin
            state_d = MEM_RESP;
            if (!s_hit && !d_hit) begin
                err_d = MEM_UNMAPPED;
            end else if (wprot) begin
                err_d = MEM_WPROT;
            end else begin
                err_d = MEM_OK;
            end
            if (req_write) begin
                src_d = SRC_NONE;
            end else if (s_hit) begin
                src_d = SRC_STATIC;
            end else if (d_hit) begin
                src_d = SRC_DYNAMIC;
            end else begin
                src_d = SRC_NONE;
            end
        end else if (state_q == MEM_RESP && rsp_ready) begin
            state_d = MEM_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            err_q   <= MEM_OK;
            src_q   <= SRC_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            src_q   <= src_d;
        end
    end

    assign rsp_valid = (state_q == MEM_RESP);
    assign rsp_err   = err_q;

    always_comb begin
        rsp_rdata = '0;
        case (src_q)
            SRC_STATIC:  rsp_rdata = s_rdata;
            SRC_DYNAMIC: rsp_rdata = d_rdata;
            default:     rsp_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_banked_memory.sv
// Scoreboard bench for banked_memory with the default memory map.
module tb_banked_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        static_lock;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    banked_memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .static_lock (static_lock),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
        string       tag;
    } exp_t;

    exp_t sb[$];
    logic [31:0] model [int];

    // Reference behaviour in global word addresses: static 0..1023, dynamic 4096..6143.
    function automatic void model_access(input bit wr, input int addr, input logic [31:0] wd,
                                         input logic [3:0] be, input bit lock,
                                         output logic [1:0] err, output logic [31:0] rd);
        bit st;
        bit dy;
        logic [31:0] w;
        st  = (addr >= 0) && (addr < 1024);
        dy  = (addr >= 4096) && (addr < 6144);
        rd  = 32'h0;
        err = 2'd0;
        w   = model.exists(addr) ? model[addr] : 32'hxxxxxxxx;
        if (!st && !dy) begin
            err = 2'd1;
        end else if (wr && st && lock) begin
            err = 2'd2;
        end else if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            end
            model[addr] = w;
        end else begin
            rd = w;
        end
    endfunction

    task automatic issue(input bit wr, input int addr, input logic [31:0] wd, input logic [3:0] be,
                         input bit lock, input string tag, output int waits);
        exp_t e;
        req_valid   = 1'b1;
        req_write   = wr;
        req_addr    = 16'(addr);
        req_wdata   = wd;
        req_be      = be;
        static_lock = lock;
        waits       = 0;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check_eq({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        model_access(wr, addr, wd, be, lock, e.err, e.rdata);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    int w;
    task automatic rd(input int addr, input string tag);
        issue(1'b0, addr, 32'h0, 4'h0, 1'b0, tag, w);
    endtask

    task automatic wr(input int addr, input logic [31:0] d, input logic [3:0] be,
                      input bit lock, input string tag);
        issue(1'b1, addr, d, be, lock, tag, w);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq({e.tag, "_err"}, {30'd0, rsp_err}, {30'd0, e.err});
                check_eq({e.tag, "_rdata"}, rsp_rdata, e.rdata);
            end
        end
    end

    int total_waits;
    int bp_waits;

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        static_lock = 1'b0;
        rsp_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("reset_rsp_err", {30'd0, rsp_err}, 32'd0);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 8; i++) wr(i, 32'h100 + i, 4'hF, 1'b0, "preload");
        wr(10, 32'hA0A0A0A0, 4'hF, 1'b0, "preload10");
        wr(1023, 32'h3FF03FF0, 4'hF, 1'b0, "preload1023");
        wr(4096, 32'h40964096, 4'hF, 1'b0, "preload4096");
        wr(6143, 32'h17FF17FF, 4'hF, 1'b0, "preload6143");

        wr(4100, 32'hDEADBEEF, 4'hF, 1'b0, "wr4100");
        rd(4100, "rd4100_full");
        wr(4100, 32'h00000011, 4'h1, 1'b0, "wr4100_be1");
        rd(4100, "rd4100_byte");

        total_waits = 0;
        for (int i = 0; i < 8; i++) begin
            rd(i, "b2b");
            total_waits += w;
        end
        check_eq("b2b_stalls", 32'(total_waits), 32'd0);

        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        rd(3, "bp_first");
        fork
            issue(1'b0, 5, 32'h0, 4'h0, 1'b0, "bp_second", bp_waits);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("bp_req_ready", {31'd0, req_ready}, 32'd0);
                    check_eq("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                    check_eq("bp_rsp_stable", rsp_rdata, 32'h103);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        check_eq("bp_accept_wait", 32'(bp_waits), 32'd3);

        wr(10, 32'h55, 4'hF, 1'b1, "lock_wr");
        rd(10, "lock_rd_old");
        wr(10, 32'h55, 4'hF, 1'b0, "unlock_wr");
        rd(10, "unlock_rd_new");

        rd(2048, "unmap_rd2048");
        wr(16'hFFFF, 32'hCAFEF00D, 4'hF, 1'b0, "unmap_wrFFFF");
        rd(1023, "static_top_intact");
        rd(6143, "dyn_top_intact");
        rd(1024, "unmap_rd1024");
        rd(4095, "unmap_rd4095");
        rd(6144, "unmap_rd6144");
        rd(4096, "dyn_base");

        wr(4100, 32'hFFFFFFFF, 4'h0, 1'b0, "be0_wr");
        rd(4100, "be0_rd");

        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        rd(4100, "rst_pending");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("async_rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        rd(4100, "post_rst_rd4100");
        rd(0, "post_rst_rd0");

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
